// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and tap extraction helper for the FIR MAC sequencer.
package fir_pkg;
  localparam int NTAPS = 10;
  localparam int DW    = 14;
  localparam int CW    = 14;
  localparam int AW    = 32;
  localparam int KW    = 4;
  localparam int PW    = DW + CW;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  // Tap 0 is the newest sample and sits in the least significant slice.
  function automatic logic signed [DW-1:0] get_tap(input logic [NTAPS*DW-1:0] taps,
                                                   input logic [KW-1:0]       k);
    return taps[k*DW +: DW];
  endfunction
endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample, result, delay-line and coefficient-configuration signals of the sequencer.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid must not depend on ready, and offered data stays stable until it transfers.
interface fir_mac_sequencer_if;
  import fir_pkg::*;

  logic                   in_valid;
  logic [DW-1:0]          in_data;
  logic                   in_ready;
  logic                   shift_en;
  logic [NTAPS*DW-1:0]    taps;
  logic                   out_valid;
  logic [AW-1:0]          out_data;
  logic                   out_ready;
  logic                   cfg_we;
  logic [KW-1:0]          cfg_addr;
  logic [CW-1:0]          cfg_data;
  logic                   cfg_err;
  logic                   busy;
  state_t                 dbg_state;

  modport master (
    output in_valid, in_data, taps, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, shift_en, out_valid, out_data, cfg_err, busy, dbg_state
  );

  modport slave (
    input  in_valid, in_data, taps, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, shift_en, out_valid, out_data, cfg_err, busy, dbg_state
  );
endinterface

// File: rtl/fir_coef_bank.sv
// NTAPS x CW coefficient register file with guarded write port and combinational read.
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [KW-1:0]        i_addr,
  input  logic [CW-1:0]        i_data,
  input  logic                 i_wr_allow,
  input  logic [KW-1:0]        i_rd_idx,
  output logic signed [CW-1:0] o_rd_data,
  output logic                 o_cfg_err
);
  logic [CW-1:0] r_coef [NTAPS];
  logic          r_err;
  logic          w_wr_ok;

  assign w_wr_ok   = i_wr_allow && (i_addr < KW'(NTAPS));
  assign o_rd_data = r_coef[i_rd_idx];
  assign o_cfg_err = r_err;

  // A rejected write leaves the bank untouched and raises a single-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) r_coef[i] <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_we) begin
        if (w_wr_ok) r_coef[i_addr] <= i_data;
        else         r_err          <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/fir_mac_sequencer.sv
// Accepts samples, shifts the external delay line and runs one MAC per tap,
// presenting each filtered result on a valid/ready output.
module fir_mac_sequencer
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  fir_mac_sequencer_if.slave bus
);
  localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [KW-1:0]          r_k;
  logic signed [AW-1:0]   r_acc;
  logic [AW-1:0]          r_out_data;
  logic                   r_out_valid;
  logic                   w_wr_allow;
  logic signed [DW-1:0]   w_tap;
  logic signed [CW-1:0]   w_coef;
  logic signed [PW-1:0]   w_prod;
  logic signed [AW-1:0]   w_prod_ext;
  logic signed [AW-1:0]   w_sum;

  assign bus.in_ready  = (r_state == IDLE);
  // Gated by reset so the delay line never moves while the sequencer is held.
  assign bus.shift_en  = bus.in_valid & bus.in_ready & reset;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = (r_state != IDLE);
  assign bus.dbg_state = r_state;

  assign w_wr_allow = (r_state == IDLE) || (r_state == DONE);

  fir_coef_bank u_coef_bank (
    .clk        (clk),
    .rst_n      (reset),
    .i_we       (bus.cfg_we),
    .i_addr     (bus.cfg_addr),
    .i_data     (bus.cfg_data),
    .i_wr_allow (w_wr_allow),
    .i_rd_idx   (r_k),
    .o_rd_data  (w_coef),
    .o_cfg_err  (bus.cfg_err)
  );

  assign w_tap      = get_tap(bus.taps, r_k);
  assign w_prod     = w_tap * w_coef;
  assign w_prod_ext = {{(AW-PW){w_prod[PW-1]}}, w_prod};
  assign w_sum      = ((r_k == '0) ? '0 : r_acc) + w_prod_ext;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.shift_en) w_next = MAC;
      MAC:     if (r_k == K_LAST) w_next = DONE;
      DONE:    if (r_out_valid && bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k         <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_state == MAC) begin
        r_acc <= w_sum;
        if (r_k == K_LAST) begin
          r_k         <= '0;
          r_out_data  <= w_sum;
          r_out_valid <= 1'b1;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
      if (r_state == DONE && r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench: behavioural delay line and dot-product model feeding an expected queue.
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NTAPS*DW-1:0] dl = '0;

  fir_mac_sequencer_if bus();

  fir_mac_sequencer dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_shift = 0;
  int coef_m [NTAPS];
  int hist   [NTAPS];
  int acc_q  [$];
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] got_q [$];
  bit prev_ov = 1'b0;

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) if (bus.shift_en) dl <= {dl[(NTAPS-1)*DW-1:0], bus.in_data};
  assign bus.taps = dl;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
    end
  endtask

  function automatic logic [AW-1:0] model_sum();
    longint s = 0;
    for (int k = 0; k < NTAPS; k++) s += longint'(coef_m[k]) * longint'(hist[k]);
    return s[AW-1:0];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.shift_en) begin
      n_shift++;
      for (int i = NTAPS-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'($signed(bus.in_data));
      if (rst_n) begin
        exp_q.push_back(model_sum());
        acc_q.push_back(cyc);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (acc_q.size() > 0) check_eq("latency", AW'(cyc - acc_q.pop_front()), AW'(NTAPS + 1));
        else                  check_eq("spurious_valid", AW'(bus.out_valid), '0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() > 0) begin
          got_q.push_back(bus.out_data);
          check_eq("result", bus.out_data, exp_q.pop_front());
        end else begin
          check_eq("unexpected_result", AW'(bus.out_valid), '0);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    int t = 0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(s);
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check_eq("send_ready", AW'(bus.in_ready), AW'(1));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      tick();
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    check_eq("drain", AW'(exp_q.size()), '0);
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_valid();
    int t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("wait_valid", AW'(bus.out_valid), AW'(1));
  endtask

  task automatic cfg_write(input int addr, input int data, input bit ok);
    tick();
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = KW'(addr);
    bus.cfg_data = CW'(data);
    tick();
    bus.cfg_we = 1'b0;
    @(negedge clk);
    check_eq("cfg_err", AW'(bus.cfg_err), ok ? '0 : AW'(1));
    @(negedge clk);
    check_eq("cfg_err_pulse", AW'(bus.cfg_err), '0);
    if (ok) coef_m[addr] = data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", AW'(bus.out_valid), '0);
    check_eq("rst_out_data",  bus.out_data, '0);
    check_eq("rst_busy",      AW'(bus.busy), '0);
    check_eq("rst_cfg_err",   AW'(bus.cfg_err), '0);
    check_eq("rst_in_ready",  AW'(bus.in_ready), AW'(1));
    check_eq("rst_shift_en",  AW'(bus.shift_en), '0);
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    // Impulse response
    for (int k = 0; k < NTAPS; k++) cfg_write(k, k + 1, 1'b1);
    got_q.delete();
    n_shift = 0;
    send(100);
    drain(1'b0);
    for (int i = 0; i < NTAPS; i++) begin
      send(0);
      drain(1'b0);
    end
    check_eq("impulse_shifts", AW'(n_shift), AW'(NTAPS + 1));
    check_eq("impulse_count", AW'(got_q.size()), AW'(NTAPS + 1));
    for (int i = 0; i <= NTAPS; i++)
      check_eq("impulse", got_q[i], (i < NTAPS) ? AW'(100 * (i + 1)) : '0);

    // Moving sum
    for (int k = 0; k < NTAPS; k++) cfg_write(k, 1, 1'b1);
    got_q.delete();
    for (int i = 1; i <= NTAPS; i++) begin
      send(i);
      drain(1'b0);
    end
    for (int i = 0; i < NTAPS; i++) check_eq("moving_sum", got_q[i], AW'((i + 1) * (i + 2) / 2));

    // Signed extremes
    for (int k = 0; k < NTAPS; k++) cfg_write(k, -8192, 1'b1);
    got_q.delete();
    for (int i = 0; i < NTAPS; i++) begin
      send(-8192);
      drain(1'b0);
    end
    check_eq("neg_full_scale", got_q[NTAPS-1], AW'(671088640));
    for (int k = 1; k < NTAPS; k++) cfg_write(k, 0, 1'b1);
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      send(8191);
      drain(1'b0);
    end
    for (int i = 0; i < 3; i++) check_eq("mixed_sign_product", got_q[i], AW'(-67100672));

    // Backpressure with in_valid held high in DONE
    for (int k = 0; k < NTAPS; k++) cfg_write(k, k - 4, 1'b1);
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(5);
    tick();
    bus.in_data  = DW'(7);
    wait_valid();
    repeat (5) begin
      check_eq("bp_valid",    AW'(bus.out_valid), AW'(1));
      check_eq("bp_data",     bus.out_data, exp_q[0]);
      check_eq("bp_in_ready", AW'(bus.in_ready), '0);
      check_eq("bp_shift_en", AW'(bus.shift_en), '0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_consume_in_ready", AW'(bus.in_ready), '0);
    @(negedge clk);
    check_eq("bp_next_in_ready", AW'(bus.in_ready), AW'(1));
    check_eq("bp_next_shift_en", AW'(bus.shift_en), AW'(1));
    tick();
    bus.in_valid = 1'b0;
    drain(1'b0);

    // Configuration rejection and DONE-time writes
    send(1234);
    cfg_write(3, 999, 1'b0);
    drain(1'b0);
    cfg_write(12, 5, 1'b0);
    bus.out_ready = 1'b0;
    send(-321);
    wait_valid();
    cfg_write(3, 777, 1'b1);
    bus.out_ready = 1'b1;
    drain(1'b0);
    send(2000);
    drain(1'b0);

    // Randomised traffic with random backpressure and configuration
    for (int n = 0; n < 25; n++) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
        int a;
        a = int'($urandom_range(0, 15));
        cfg_write(a, int'($urandom_range(0, 16383)) - 8192, a < NTAPS);
      end
      send(int'($urandom_range(0, 16383)) - 8192);
      drain(1'b1);
    end

    // Reset in the middle of MAC at k=4
    send(4321);
    repeat (4) tick();
    rst_n = 1'b0;
    for (int k = 0; k < NTAPS; k++) coef_m[k] = 0;
    bus.in_valid = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", AW'(bus.out_valid), '0);
    check_eq("mid_rst_out_data",  bus.out_data, '0);
    check_eq("mid_rst_busy",      AW'(bus.busy), '0);
    check_eq("mid_rst_in_ready",  AW'(bus.in_ready), AW'(1));
    check_eq("mid_rst_shift_en",  AW'(bus.shift_en), '0);
    bus.in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", AW'(bus.in_ready), AW'(1));
    got_q.delete();
    send(1500);
    drain(1'b0);
    check_eq("post_rst_zero", got_q[0], '0);
    cfg_write(0, 3, 1'b1);
    send(10);
    drain(1'b0);
    check_eq("post_rst_rewrite", got_q[1], AW'(30));

    check_eq("pending", AW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
